// File: rtl/adder4_seq_ctrl.sv
// Nibble-serial add sequencer: drives one external 4-bit adder per clock, LS nibble first,
// chaining the carry through a register and assembling the WIDTH-bit sum.
module adder4_seq_ctrl #(
  parameter int WIDTH = 16  // multiple of 4, >= 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cin,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic [3:0]       add_a,
  output logic [3:0]       add_b,
  output logic             add_ci,
  input  logic [3:0]       add_s,
  input  logic             add_co
);

  localparam int NIB = WIDTH / 4;
  localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NIB - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      x_q     <= x_d;
      y_q     <= y_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    x_d     = x_q;
    y_d     = y_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          x_d     = x;
          y_d     = y;
          carry_d = cin;
          idx_d   = '0;
          sum_d   = '0;
          cout_d  = 1'b0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        // Adder output is combinational on registered operands: capture it this edge.
        sum_d[4*idx_q +: 4] = add_s;
        carry_d             = add_co;
        if (idx_q == LAST_IDX) begin
          cout_d  = add_co;
          idx_d   = '0;
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Status and adder drive decode only registered state; start never reaches done.
  always_comb begin
    ready  = (state_q == S_IDLE);
    busy   = (state_q == S_RUN);
    done   = (state_q == S_DONE);
    add_a  = 4'h0;
    add_b  = 4'h0;
    add_ci = 1'b0;
    if (state_q == S_RUN) begin
      add_a  = x_q[4*idx_q +: 4];
      add_b  = y_q[4*idx_q +: 4];
      add_ci = carry_q;
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_adder4_seq_ctrl.sv
// Directed and random bench for adder4_seq_ctrl with a behavioural 4-bit adder as datapath.
module tb_adder4_seq_ctrl;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         start;
  logic [W-1:0] x, y;
  logic         cin;
  logic         ready, busy, done, cout;
  logic [W-1:0] sum;
  logic [3:0]   add_a, add_b, add_s;
  logic         add_ci, add_co;
  logic [4:0]   add_full;

  int n_vec = 0;
  int n_err = 0;

  adder4_seq_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .x(x), .y(y), .cin(cin),
    .ready(ready), .busy(busy), .done(done), .sum(sum), .cout(cout),
    .add_a(add_a), .add_b(add_b), .add_ci(add_ci), .add_s(add_s), .add_co(add_co)
  );

  assign add_full = {1'b0, add_a} + {1'b0, add_b} + {4'b0, add_ci};
  assign add_s    = add_full[3:0];
  assign add_co   = add_full[4];

  always #5 clk = ~clk;

  // One transaction from IDLE; returns result, per-RUN-cycle add_a/add_ci trace and
  // the cycle (counted from the start edge) in which done was seen.
  task automatic do_op(input logic [W-1:0] xa, input logic [W-1:0] ya, input logic ca,
                       output logic [W-1:0] s, output logic co,
                       output logic [15:0] aseq, output logic [3:0] ciseq, output int lat);
    int k;
    k = 0; aseq = '0; ciseq = '0; lat = 0;
    x = xa; y = ya; cin = ca; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; lat = 1;
    while (!done && lat < 20) begin
      if (busy && k < 4) begin
        aseq[4*k +: 4] = add_a;
        ciseq[k]       = add_ci;
        k++;
      end
      @(posedge clk); #1;
      lat++;
    end
    s = sum; co = cout;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 1'b0; x = '0; y = '0; cin = 1'b0;
    #12;
    n_vec++;
    if ({ready, busy, done} !== 3'b100) begin
      n_err++; $display("FAIL reset_status got %b exp 100", {ready, busy, done});
    end
    n_vec++;
    if ({cout, sum} !== 17'h0) begin
      n_err++; $display("FAIL reset_result got %h exp 00000", {cout, sum});
    end
    n_vec++;
    if ({add_a, add_b, add_ci} !== 9'h0) begin
      n_err++; $display("FAIL reset_adder_drive got %h exp 000", {add_a, add_b, add_ci});
    end
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    logic [W-1:0] s; logic co; logic [15:0] aseq; logic [3:0] ciseq; int lat;
    do_op(16'h1234, 16'h4321, 1'b0, s, co, aseq, ciseq, lat);
    n_vec++;
    if ({co, s} !== 17'h05555) begin
      n_err++; $display("FAIL basic_result got %h exp 05555", {co, s});
    end
    n_vec++;
    if (aseq !== 16'h1234) begin
      n_err++; $display("FAIL basic_add_a_seq got %h exp 1234 (nibble0 first)", aseq);
    end
    n_vec++;
    if (lat !== 5) begin
      n_err++; $display("FAIL basic_latency got %0d exp 5", lat);
    end
    n_vec++;
    if ({ready, done, busy} !== 3'b100) begin
      n_err++; $display("FAIL basic_back_to_idle got %b exp 100", {ready, done, busy});
    end
  endtask

  task automatic test_carry();
    logic [W-1:0] s; logic co; logic [15:0] aseq; logic [3:0] ciseq; int lat;
    do_op(16'hFFFF, 16'h0001, 1'b0, s, co, aseq, ciseq, lat);
    n_vec++;
    if ({co, s} !== 17'h10000) begin
      n_err++; $display("FAIL ripple_result got %h exp 10000", {co, s});
    end
    n_vec++;
    if (ciseq !== 4'b1110) begin
      n_err++; $display("FAIL ripple_add_ci_seq got %b exp 1110 (cycle0 is lsb)", ciseq);
    end
    do_op(16'hFFFF, 16'h0000, 1'b1, s, co, aseq, ciseq, lat);
    n_vec++;
    if ({co, s} !== 17'h10000) begin
      n_err++; $display("FAIL cin_ripple got %h exp 10000", {co, s});
    end
    do_op(16'h00FF, 16'h0F01, 1'b1, s, co, aseq, ciseq, lat);
    n_vec++;
    if ({co, s} !== 17'h01001) begin
      n_err++; $display("FAIL cin_mid got %h exp 01001", {co, s});
    end
  endtask

  task automatic test_start_while_busy();
    int dones; logic [W-1:0] s; logic co;
    dones = 0; s = '0; co = 1'b0;
    x = 16'h1234; y = 16'h4321; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; x = 16'h1111; y = 16'h1111; cin = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; x = '0; y = '0; cin = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (done) begin dones++; s = sum; co = cout; end
      @(posedge clk); #1;
    end
    n_vec++;
    if (dones !== 1) begin
      n_err++; $display("FAIL busy_start_done_count got %0d exp 1", dones);
    end
    n_vec++;
    if ({co, s} !== 17'h05555) begin
      n_err++; $display("FAIL busy_start_result got %h exp 05555", {co, s});
    end
    n_vec++;
    if (ready !== 1'b1) begin
      n_err++; $display("FAIL busy_start_ready got %b exp 1", ready);
    end
  endtask

  task automatic test_reset_mid_op();
    int dones; logic [W-1:0] s; logic co; logic [15:0] aseq; logic [3:0] ciseq; int lat;
    dones = 0;
    x = 16'hFFFF; y = 16'h0001; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_vec++;
    if (busy !== 1'b1) begin
      n_err++; $display("FAIL midreset_precond_busy got %b exp 1", busy);
    end
    reset_n = 1'b0;
    #1;
    n_vec++;
    if ({ready, busy, done, cout, sum, add_a, add_b, add_ci} !== {3'b100, 1'b0, 16'h0, 9'h0}) begin
      n_err++; $display("FAIL midreset_outputs got %h exp %h",
                        {ready, busy, done, cout, sum, add_a, add_b, add_ci},
                        {3'b100, 1'b0, 16'h0, 9'h0});
    end
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    @(negedge clk); reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    n_vec++;
    if (dones !== 0) begin
      n_err++; $display("FAIL midreset_no_done got %0d exp 0", dones);
    end
    do_op(16'h00FF, 16'h0F01, 1'b1, s, co, aseq, ciseq, lat);
    n_vec++;
    if ({co, s} !== 17'h01001) begin
      n_err++; $display("FAIL midreset_next_op got %h exp 01001", {co, s});
    end
  endtask

  task automatic test_random();
    logic [W-1:0] s; logic co; logic [15:0] aseq; logic [3:0] ciseq; int lat;
    logic [W-1:0] xa, ya; logic ca; logic [W:0] exp_v;
    for (int i = 0; i < 1000; i++) begin
      xa = W'($urandom);
      ya = W'($urandom);
      ca = 1'($urandom_range(0, 1));
      exp_v = {1'b0, xa} + {1'b0, ya} + {{W{1'b0}}, ca};
      do_op(xa, ya, ca, s, co, aseq, ciseq, lat);
      n_vec++;
      if ({co, s} !== exp_v || lat !== 5) begin
        n_err++;
        $display("FAIL random_%0d x=%h y=%h cin=%b got %h lat %0d exp %h lat 5",
                 i, xa, ya, ca, {co, s}, lat, exp_v);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry();
    test_start_while_busy();
    test_reset_mid_op();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
